// File: rtl/fb_pixel_writer.sv
// Write-side front end for the RGB frame buffer: turns a raster pixel stream into
// registered write strobes, linear addresses and colour data, with framing-error resync.
module fb_pixel_writer #(
    parameter int unsigned H_PIX = 100,
    parameter int unsigned V_PIX = 100,
    parameter int unsigned AW    = 16,
    parameter int unsigned CW    = 6
) (
    input  logic          clkq,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_sof,
    input  logic          s_eol,
    input  logic [CW-1:0] s_r,
    input  logic [CW-1:0] s_g,
    input  logic [CW-1:0] s_b,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [CW-1:0] wr_r,
    output logic [CW-1:0] wr_g,
    output logic [CW-1:0] wr_b,
    output logic          frame_done,
    output logic          err_sync,
    output logic          busy,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned CLW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int unsigned RLW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
    localparam int unsigned FCW = 8;
    localparam logic [CLW-1:0] COL_LAST = CLW'(H_PIX - 1);
    localparam logic [RLW-1:0] ROW_LAST = RLW'(V_PIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CLW-1:0]  col_q, col_d;
    logic [RLW-1:0]  row_q, row_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [CW-1:0]   wr_r_q, wr_r_d;
    logic [CW-1:0]   wr_g_q, wr_g_d;
    logic [CW-1:0]   wr_b_q, wr_b_d;
    logic            frame_done_q, frame_done_d;
    logic            err_sync_q, err_sync_d;
    logic            busy_q, busy_d;
    logic            s_ready_q, s_ready_d;
    logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;

    logic            accept;
    logic            take;
    logic            mid_sof;
    logic            eol_ok;
    logic            last_pix;
    logic [CLW-1:0]  eff_col;
    logic [RLW-1:0]  eff_row;
    logic [AW-1:0]   eff_addr;

    // A start-of-frame pixel always lands at position 0, whether it opens or restarts a frame.
    assign accept   = s_valid & s_ready_q;
    assign take     = accept & ((state_q == ST_WRITE) | ((state_q == ST_IDLE) & s_sof));
    assign mid_sof  = (state_q == ST_WRITE) & s_sof;
    assign eff_col  = s_sof ? '0 : col_q;
    assign eff_row  = s_sof ? '0 : row_q;
    assign eff_addr = s_sof ? '0 : addr_q;
    assign eol_ok   = (s_eol == (eff_col == COL_LAST));
    assign last_pix = (eff_col == COL_LAST) & (eff_row == ROW_LAST);

    always_ff @(posedge clkq or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_r_q       <= '0;
            wr_g_q       <= '0;
            wr_b_q       <= '0;
            frame_done_q <= 1'b0;
            err_sync_q   <= 1'b0;
            busy_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_r_q       <= wr_r_d;
            wr_g_q       <= wr_g_d;
            wr_b_q       <= wr_b_d;
            frame_done_q <= frame_done_d;
            err_sync_q   <= err_sync_d;
            busy_q       <= busy_d;
            s_ready_q    <= s_ready_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (take) begin
                    if (!eol_ok) begin
                        state_d = ST_IDLE;
                    end else if (last_pix) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_r_d       = wr_r_q;
        wr_g_d       = wr_g_q;
        wr_b_d       = wr_b_q;
        frame_done_d = 1'b0;
        err_sync_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        s_ready_d    = (state_d != ST_DONE);
        busy_d       = (state_d == ST_WRITE);

        if (take) begin
            err_sync_d = mid_sof | ~eol_ok;
            if (eol_ok) begin
                wr_en_d   = 1'b1;
                wr_addr_d = eff_addr;
                wr_r_d    = s_r;
                wr_g_d    = s_g;
                wr_b_d    = s_b;
                addr_d    = eff_addr + AW'(1);
                if (eff_col == COL_LAST) begin
                    col_d = '0;
                    row_d = eff_row + RLW'(1);
                end else begin
                    col_d = eff_col + CLW'(1);
                    row_d = eff_row;
                end
            end else begin
                col_d  = '0;
                row_d  = '0;
                addr_d = '0;
            end
        end

        // Completion: pulse alongside the last write and rewind for the next frame.
        if (state_d == ST_DONE) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FCW'(1);
            col_d        = '0;
            row_d        = '0;
            addr_d       = '0;
        end
    end

    assign s_ready    = s_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_r       = wr_r_q;
    assign wr_g       = wr_g_q;
    assign wr_b       = wr_b_q;
    assign frame_done = frame_done_q;
    assign err_sync   = err_sync_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
Write-side companion to the 6-bit-per-channel RGB frame buffer, which stores R, G and B in separate arrays at 100x100 = 10000 entries each. Accepts a raster-ordered pixel stream with valid/ready handshake and start-of-frame/end-of-line markers. Generates a registered write enable, a linear write address and the RGB write data for the buffer's write port. Detects framing errors, resynchronises on them, and reports frame completion.

Parameters:
H_PIX, 100, pixels per line
V_PIX, 100, lines per frame
AW, 16, write address width; must satisfy H_PIX*V_PIX <= 2^AW
CW, 6, bits per colour channel

Ports:
clkq  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input pixel valid
s_ready  out  1  block can accept a pixel this cycle
s_sof  in  1  pixel is first of frame (row 0, col 0); qualified by s_valid
s_eol  in  1  pixel is last of its line; qualified by s_valid
s_r, s_g, s_b  in  CW each  input pixel colour
wr_en  out  1  write strobe to frame buffer
wr_addr  out  AW  linear write address, row*H_PIX+col
wr_r, wr_g, wr_b  out  CW each  write data
frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
err_sync  out  1  one-cycle pulse on any framing error
busy  out  1  high while in WRITE state
frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (async on rst_n low): state IDLE; col, row, wr_addr = 0; wr_en, frame_done, err_sync, busy, s_ready = 0; wr_r/g/b = 0; frame_cnt = 0. s_ready rises on the first clkq edge after reset release.
- Accept = s_valid & s_ready. Only accepted pixels affect state.
- FSM states:
  - IDLE: s_ready=1. Accepted pixel with s_sof=0 is discarded silently. Accepted pixel with s_sof=1 is written at address 0, col advances to 1 (or to 0 with row 1 when H_PIX=1), go to WRITE.
  - WRITE: s_ready=1, busy=1. Each accepted pixel is written at the current address, then col/address advance.
  - DONE: lasts one cycle. s_ready=0, frame_done=1, frame_cnt increments, then go to IDLE.
- Write timing: the pixel accepted in cycle N produces wr_en=1 in cycle N+1, with wr_addr and wr_r/g/b registered copies of that pixel's address and data (latency 1). wr_en=0 on every cycle with no accepted, written pixel. wr_addr and data hold their last values when wr_en=0.
- Addressing:
  - wr_addr is maintained incrementally: +1 per written pixel; no multiplier.
  - At col == H_PIX-1, col wraps to 0 and row increments.
  - The pixel at row V_PIX-1, col H_PIX-1 is the last of the frame: it is written and the FSM enters DONE. frame_done is asserted in the same cycle as that pixel's wr_en.
- EOL check (WRITE and the IDLE->WRITE pixel): s_eol must equal (col == H_PIX-1).
  - On mismatch: pixel discarded (no wr_en), err_sync pulses next cycle, state goes to IDLE, counters clear.
- SOF mid-frame (WRITE, s_sof=1 accepted): err_sync pulses next cycle and the frame restarts. That pixel is written at address 0, col=1, row=0, and the state stays WRITE. frame_cnt is not incremented.
- Simultaneous errors: if sof mid-frame and an eol mismatch occur on the same pixel, sof-restart takes priority and the eol check is evaluated against col 0.
- Back-to-back frames: a pixel offered during DONE is stalled (s_ready=0) and accepted next cycle in IDLE.
- Reset mid-frame: immediate return to reset values. The partial frame is abandoned and no frame_done is produced.

Test Plan:
- Full 100x100 frame streamed with s_valid held at 1, sof on the first pixel, eol on each col 99 -> 10000 wr_en pulses, addresses 0..9999 in order, data equal to input delayed 1 cycle, frame_done pulse coincident with addr 9999, frame_cnt=1, s_ready=0 for exactly one cycle.
- 5 pixels without sof while in IDLE, then a frame -> the first 5 pixels produce no wr_en; the first write is at addr 0 with the sof pixel's data.
- Random s_valid gaps (about 30% idle) across a full frame -> the same address/data sequence as the gapless case; wr_en only on cycles following an accept.
- sof reasserted at pixel 250 (row 2, col 50) -> err_sync pulse, that pixel written at addr 0, the following pixels at 1, 2, ...; frame_cnt unchanged until the restarted frame completes.
- eol asserted at col 40 of row 0 -> no write for that pixel, err_sync pulse, return to IDLE; the next non-sof pixels are discarded.
- rst_n pulsed low at pixel 5000 -> all outputs 0 asynchronously; after release, a new full frame completes normally with frame_cnt=1.
